// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC and picks the next PC from sequential, branch and jump requests.
// Latency: zero cycles from instr_in to instr_out. A PC request takes effect at the next rising edge.
// Backpressure: stall holds PC, count and state, and drops any branch or jump seen that cycle.
// With FETCH_HALT_EN defined, an all-zero instruction word parks the unit in HALT until rst.
// Without it, an all-zero word is an ordinary NOP and fetch never stops.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          ADDR_W   = 5,
    parameter int          COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [15:0]        branch_offset,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic [31:0]        instr_in,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr_out,
    output logic               instr_valid,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count
);

    // PC is always word aligned, so the low two bits of the reset value are dropped.
    localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] next_pc;
    logic        advance;

    // Byte offset of a taken branch: sign-extended word offset times four.
    logic [31:0] branch_disp;
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    assign pc_plus4  = pc + 32'd4;
    assign branch_pc = pc_plus4 + branch_disp;
    assign jump_pc   = {pc_plus4[31:28], jump_target, 2'b00};
    // Low word-index bits only, so sequential fetch wraps word 31 -> 0 on its own.
    assign imem_addr = pc[ADDR_W+1:2];

    // Next-PC select: jump beats branch, branch beats sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

`ifdef FETCH_HALT_EN
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    logic   valid_q;
    logic   halted_q;
    logic   zero_instr;

    assign zero_instr = (instr_in == 32'h0);

    // The edge that sees the zero word moves to HALT instead of advancing the PC.
    assign advance = (state == RUN) && !stall && !zero_instr;

    // Run/halt state with registered valid and halted flags; only rst leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall && zero_instr) begin
                        state    <= HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    state    <= HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    valid_q  <= 1'b1;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_valid = valid_q;
    assign halted      = halted_q;
    // Decode sees a bubble of zeros once fetch has stopped.
    assign instr_out   = valid_q ? instr_in : 32'h0;
`else
    // No halt state: every unstalled edge advances, zero words included.
    assign advance     = !stall;
    assign instr_valid = 1'b1;
    assign halted      = 1'b0;
    assign instr_out   = instr_in;
`endif

    // PC register and saturating fetch counter, both move only on advancing edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC_INIT;
            fetch_count <= '0;
        end else if (advance) begin
            pc <= next_pc;
            if (fetch_count != {COUNT_W{1'b1}}) begin
                fetch_count <= fetch_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 32-word instruction memory model.
// Words 0..21 hold nonzero instructions, words 22..31 are zero.
// Halt-specific expectations follow whether FETCH_HALT_EN is defined for the build.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] instr_in;
    logic [4:0]  imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] imem [32];

    int total;
    int bad;

    fetch_unit #(
        .PC_RESET(32'h0000_0000),
        .ADDR_W  (5),
        .COUNT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .instr_in     (instr_in),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign instr_in = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) begin
            imem[i] = (i < 22) ? (32'h2000_0000 + 32'(i) + 32'h100) : 32'h0;
        end
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        step(2);
        rst = 1'b0;

        // Reset state
        check("rst_pc",     pc,          32'h0);
        check("rst_addr",   imem_addr,   32'd0);
        check("rst_count",  fetch_count, 32'd0);
        check("rst_valid",  instr_valid, 32'd1);
        check("rst_halted", halted,      32'd0);
        check("rst_pc4",    pc_plus4,    32'h4);
        check("rst_instr",  instr_out,   32'h2000_0100);

        // Ten sequential fetches
        step(10);
        check("seq_pc",    pc,          32'h28);
        check("seq_addr",  imem_addr,   32'd10);
        check("seq_count", fetch_count, 32'd10);
        check("seq_valid", instr_valid, 32'd1);
        check("seq_instr", instr_out,   32'h2000_010A);

        // Backward branch from 0x14: 0x18 - 12 = 0x0C
        do_reset();
        step(5);
        check("br_start", pc, 32'h14);
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFD;
        step(1);
        check("br_pc",    pc,          32'h0C);
        check("br_addr",  imem_addr,   32'd3);
        check("br_count", fetch_count, 32'd6);

        // Jump and branch together: jump to 0x40 wins
        jump        = 1'b1;
        jump_target = 26'h10;
        step(1);
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("jb_pc",    pc,          32'h40);
        check("jb_addr",  imem_addr,   32'd16);
        check("jb_count", fetch_count, 32'd7);

        // Stall with a pending branch for three cycles at 0x08
        do_reset();
        step(2);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'h0005;
        step(3);
        check("st_pc",    pc,          32'h08);
        check("st_count", fetch_count, 32'd2);
        check("st_valid", instr_valid, 32'd1);
        stall        = 1'b0;
        branch_taken = 1'b0;
        step(1);
        check("st_rel_pc",    pc,          32'h0C);
        check("st_rel_count", fetch_count, 32'd3);

        // Reset overrides a stall and a jump on the same edge
        rst         = 1'b1;
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 26'h10;
        step(1);
        rst   = 1'b0;
        stall = 1'b0;
        jump  = 1'b0;
        check("rj_pc",    pc,          32'h0);
        check("rj_count", fetch_count, 32'd0);

        // Most negative branch wraps below zero: 4 - 0x20000
        branch_taken  = 1'b1;
        branch_offset = 16'h8000;
        step(1);
        branch_taken = 1'b0;
        check("neg_pc",   pc,        32'hFFFE_0004);
        check("neg_addr", imem_addr, 32'd1);
        // Jump keeps the upper nibble of pc+4
        jump        = 1'b1;
        jump_target = 26'h3;
        step(1);
        jump = 1'b0;
        check("jhi_pc",    pc,          32'hF000_000C);
        check("jhi_count", fetch_count, 32'd2);

        // Run into the zero word at index 22
        do_reset();
        step(22);
        check("z_pc",    pc,        32'h58);
        check("z_instr", instr_in,  32'h0);
`ifdef FETCH_HALT_EN
        step(1);
        check("h_halted", halted,      32'd1);
        check("h_valid",  instr_valid, 32'd0);
        check("h_pc",     pc,          32'h58);
        check("h_count",  fetch_count, 32'd22);
        check("h_instr",  instr_out,   32'h0);
        jump         = 1'b1;
        branch_taken = 1'b1;
        step(3);
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("h_frozen_pc", pc,     32'h58);
        check("h_frozen_h",  halted, 32'd1);
        do_reset();
        check("h_rst_pc",     pc,          32'h0);
        check("h_rst_halted", halted,      32'd0);
        check("h_rst_valid",  instr_valid, 32'd1);
`else
        check("nop_valid", instr_valid, 32'd1);
        check("nop_instr", instr_out,   32'h0);
        step(10);
        check("wrap_pc",     pc,          32'h80);
        check("wrap_addr",   imem_addr,   32'd0);
        check("wrap_count",  fetch_count, 32'd32);
        check("wrap_halted", halted,      32'd0);
        check("wrap_instr",  instr_out,   32'h2000_0100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle datapath. Holds the program counter and computes the next PC from sequential, branch and jump requests. Drives the 5-bit word index into the 32-word instruction memory and passes the returned instruction to decode with a valid flag. Optionally halts fetch when it sees an all-zero instruction word, and keeps a fetch counter for bench and debug use.

## Interface
- PC_RESET, 32'h0000_0000, byte address loaded into PC on reset (word aligned)
- ADDR_W, 5, width of the word index driven to instruction memory
- COUNT_W, 16, width of the fetch counter

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold PC and state this cycle
- branch_taken  in  1  take branch at this edge
- branch_offset  in  16  signed word offset (MIPS imm16)
- jump  in  1  take jump at this edge
- jump_target  in  26  MIPS J-format target field
- instr_in  in  32  instruction word returned combinationally by instruction memory
- imem_addr  out  ADDR_W  word index to instruction memory, = pc[ADDR_W+1:2]
- pc  out  32  current PC (byte address)
- pc_plus4  out  32  pc + 4, combinational
- instr_out  out  32  instruction to decode
- instr_valid  out  1  instr_out is a live fetch
- halted  out  1  fetch unit is in HALT
- fetch_count  out  COUNT_W  number of advancing edges since reset

## Operation
- States: RUN, HALT. Reset enters RUN. HALT exits only through rst.
- RUN, stall=1: PC, count and state hold. instr_valid stays 1.
- RUN, stall=0: PC loads next_pc and fetch_count increments, saturating at all-ones.
- next_pc priority:
  - jump: {pc_plus4[31:28], jump_target, 2'b00}
  - else branch_taken: pc_plus4 + (sext(branch_offset) << 2)
  - else pc_plus4
- All PC arithmetic is 32-bit modulo 2^32. Bits [1:0] are always 0.
- imem_addr takes the low word-index bits, so sequential fetch wraps from word 31 to word 0 with no special handling. The upper PC bits keep counting.
- instr_out = instr_in when in RUN, 32'h0 when in HALT.
- instr_valid = (state==RUN). halted = (state==HALT).
- HALT: PC, count and outputs are frozen. stall, branch_taken and jump are ignored.
- Simultaneous jump and branch_taken: jump wins. stall overrides both (the request is dropped, not queued).

## Timing
- Reset values: pc=PC_RESET, imem_addr=PC_RESET[ADDR_W+1:2], fetch_count=0, instr_valid=1, halted=0.
- instr_out follows instr_in combinationally. Zero-cycle fetch latency for the single-cycle datapath.
- PC update takes effect one edge after the request. Branch and jump inputs are sampled only at that edge.
- rst asserted at any edge, including mid-stall or in HALT, overrides everything else. The next cycle shows reset values.
- Halt entry (macro enabled): at the edge where state=RUN, stall=0 and instr_in==0:
  - state goes to HALT.
  - PC and count do not advance on that edge.
  - instr_valid drops in the following cycle.

## Configuration
- FETCH_HALT_EN defined: halt-on-zero-instruction detection is compiled in, as described above.
- FETCH_HALT_EN undefined: no HALT state.
  - An all-zero word is treated as a NOP (sll $0,$0,0) and fetch advances normally.
  - halted is tied 0 and instr_valid is tied 1.

## Test plan
- Reset then 10 unstalled cycles with no branch or jump -> pc=0x28, imem_addr=10, fetch_count=10, instr_valid=1.
- At pc=0x14, branch_taken=1 with branch_offset=16'hFFFD -> next pc=0x0C, imem_addr=3. Same edge with jump=1 and jump_target=26'h10 -> pc=0x40 (jump wins).
- stall held for 3 cycles at pc=0x08 with branch_taken=1 -> pc stays 0x08 and fetch_count is unchanged. Releasing stall with no request gives pc=0x0C.
- FETCH_HALT_EN, memory nonzero at words 0..21 and zero at word 22 -> halted=1 after reaching word 22, pc frozen at 0x58, fetch_count=22, instr_out=0, instr_valid=0. A later rst gives pc=0, halted=0.
- FETCH_HALT_EN undefined, same memory -> no halt. After 32 cycles pc=0x80, imem_addr=0, fetch_count=32.
- rst asserted while stall=1 and jump=1 -> next cycle pc=PC_RESET and fetch_count=0. The jump is not taken.
